// File: rtl/probe_result_collector.sv
// rtl/probe_result_collector.sv - reorders 8-lane probe results into in-order 512-bit beats and returns curr_sn credit
module probe_result_collector #(
  parameter int MAX_IN_TRANSIT = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [7:0]   in_valid,
  output logic [7:0]   in_ready,
  input  logic [511:0] in_data,
  input  logic [7:0]   in_hit,
  input  logic [511:0] in_serialnum,
  input  logic [7:0]   in_last,
  output logic [511:0] out_data,
  output logic [7:0]   out_keep,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_last,
  output logic [31:0]  curr_sn,
  output logic         err_sn
);

  localparam int          IDXW = (MAX_IN_TRANSIT > 1) ? $clog2(MAX_IN_TRANSIT) : 1;
  localparam logic [31:0] WIN  = 32'(MAX_IN_TRANSIT);

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  // Slot index is the serial number modulo the window size (power of two).
  function automatic logic [IDXW-1:0] slot_of(input logic [31:0] sn);
    return IDXW'(sn % WIN);
  endfunction

  logic [511:0] slot_data_q [MAX_IN_TRANSIT];
  logic [511:0] slot_data_d [MAX_IN_TRANSIT];
  logic [7:0]   slot_hit_q  [MAX_IN_TRANSIT];
  logic [7:0]   slot_hit_d  [MAX_IN_TRANSIT];
  logic [7:0]   slot_fill_q [MAX_IN_TRANSIT];
  logic [7:0]   slot_fill_d [MAX_IN_TRANSIT];
  logic         slot_last_q [MAX_IN_TRANSIT];
  logic         slot_last_d [MAX_IN_TRANSIT];

  logic [511:0] out_data_q, out_data_d;
  logic [7:0]   out_keep_q, out_keep_d;
  logic         out_valid_q, out_valid_d;
  logic         out_last_q, out_last_d;
  logic [31:0]  curr_sn_q, curr_sn_d;
  logic         err_sn_q, err_sn_d;
  logic [1:0]   state_q, state_d;
  // Keeps in_ready low while reset is applied and for the first cycle after it.
  logic         armed_q, armed_d;

  logic [31:0]     lane_diff [8];
  logic [IDXW-1:0] lane_slot [8];
  logic [7:0]      lane_win, lane_behind, lane_idx_bad;
  logic [IDXW-1:0] head;
  logic            retire;

  // Per-lane window classification and ready; purely from registered state and serial numbers.
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      lane_diff[i]    = in_serialnum[64*i +: 32] - curr_sn_q;
      lane_slot[i]    = slot_of(in_serialnum[64*i +: 32]);
      lane_win[i]     = lane_diff[i] < WIN;
      lane_behind[i]  = lane_diff[i][31];
      lane_idx_bad[i] = in_serialnum[64*i+32 +: 32] != 32'(i);
      in_ready[i]     = armed_q && (state_q == ST_RUN) &&
                        ((lane_win[i] && !slot_fill_q[lane_slot[i]][i]) || lane_behind[i]);
    end
  end

  // Next-state: retire the head slot, then fold in accepted lane words, then FSM.
  always_comb begin
    slot_data_d = slot_data_q;
    slot_hit_d  = slot_hit_q;
    slot_fill_d = slot_fill_q;
    slot_last_d = slot_last_q;
    out_data_d  = out_data_q;
    out_keep_d  = out_keep_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    curr_sn_d   = curr_sn_q;
    err_sn_d    = err_sn_q;
    state_d     = state_q;
    armed_d     = 1'b1;

    head   = slot_of(curr_sn_q);
    retire = (state_q == ST_RUN) && (&slot_fill_q[head]) && (!out_valid_q || out_ready);

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    if (retire) begin
      out_data_d        = slot_data_q[head];
      out_keep_d        = slot_hit_q[head];
      out_valid_d       = (|slot_hit_q[head]) || slot_last_q[head];
      out_last_d        = slot_last_q[head];
      slot_data_d[head] = '0;
      slot_hit_d[head]  = '0;
      slot_fill_d[head] = '0;
      slot_last_d[head] = 1'b0;
      curr_sn_d         = curr_sn_q + 32'd1;
      if (slot_last_q[head]) begin
        state_d = ST_DRAIN;
      end
    end

    // The head slot is full when it retires, so no lane can write it this cycle.
    for (int i = 0; i < 8; i++) begin
      if (in_valid[i] && in_ready[i]) begin
        if (lane_behind[i]) begin
          err_sn_d = 1'b1;
        end else begin
          slot_data_d[lane_slot[i]][64*i +: 64] = in_data[64*i +: 64];
          slot_hit_d[lane_slot[i]][i]           = in_hit[i];
          slot_fill_d[lane_slot[i]][i]          = 1'b1;
          slot_last_d[lane_slot[i]]             = slot_last_d[lane_slot[i]] | in_last[i];
          if (lane_idx_bad[i]) begin
            err_sn_d = 1'b1;
          end
        end
      end
    end

    if ((state_q == ST_DRAIN) && out_valid_q && out_ready && out_last_q) begin
      state_d = ST_DONE;
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < MAX_IN_TRANSIT; s++) begin
        slot_data_q[s] <= '0;
        slot_hit_q[s]  <= '0;
        slot_fill_q[s] <= '0;
        slot_last_q[s] <= 1'b0;
      end
      out_data_q  <= '0;
      out_keep_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      curr_sn_q   <= '0;
      err_sn_q    <= 1'b0;
      state_q     <= ST_RUN;
      armed_q     <= 1'b0;
    end else begin
      slot_data_q <= slot_data_d;
      slot_hit_q  <= slot_hit_d;
      slot_fill_q <= slot_fill_d;
      slot_last_q <= slot_last_d;
      out_data_q  <= out_data_d;
      out_keep_q  <= out_keep_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      curr_sn_q   <= curr_sn_d;
      err_sn_q    <= err_sn_d;
      state_q     <= state_d;
      armed_q     <= armed_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_keep  = out_keep_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign curr_sn   = curr_sn_q;
  assign err_sn    = err_sn_q;

endmodule

// File: tb/tb_probe_result_collector.sv
// tb/tb_probe_result_collector.sv - directed self-checking bench for probe_result_collector
module tb_probe_result_collector;

  logic         clk = 1'b0;
  logic         reset;
  logic [7:0]   in_valid;
  logic [7:0]   in_ready;
  logic [511:0] in_data;
  logic [7:0]   in_hit;
  logic [511:0] in_serialnum;
  logic [7:0]   in_last;
  logic [511:0] out_data;
  logic [7:0]   out_keep;
  logic         out_valid;
  logic         out_ready;
  logic         out_last;
  logic [31:0]  curr_sn;
  logic         err_sn;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  probe_result_collector #(.MAX_IN_TRANSIT(2)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_hit(in_hit),
    .in_serialnum(in_serialnum), .in_last(in_last),
    .out_data(out_data), .out_keep(out_keep), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .curr_sn(curr_sn), .err_sn(err_sn)
  );

  // Lane word encodes its serial number and lane so beat contents identify the batch.
  function automatic logic [63:0] lane_word(input int i, input logic [31:0] sn);
    return {32'hD000_0000 | sn, 32'(i)};
  endfunction

  function automatic logic [511:0] exp_data(input logic [31:0] sn);
    logic [511:0] d;
    for (int i = 0; i < 8; i++) d[64*i +: 64] = lane_word(i, sn);
    return d;
  endfunction

  task automatic set_lane(input int i, input logic [31:0] sn, input logic [31:0] idx,
                          input logic hit, input logic last, input logic vld);
    in_serialnum[64*i +: 64] = {idx, sn};
    in_data[64*i +: 64]      = lane_word(i, sn);
    in_hit[i]                = hit;
    in_last[i]               = last;
    in_valid[i]              = vld;
  endtask

  task automatic set_batch(input logic [31:0] sn, input logic [7:0] hit, input logic last,
                           input logic [7:0] vld);
    for (int i = 0; i < 8; i++) set_lane(i, sn, 32'(i), hit[i], last, vld[i]);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    in_valid = '0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; out_ready = 1'b0;
    set_batch(32'd0, 8'h00, 1'b0, 8'h00);
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0h expected 0", out_valid); end
    checks++; if (out_data !== 512'd0) begin errors++; $display("FAIL reset_out_data: got %0h expected 0", out_data); end
    checks++; if (out_keep !== 8'h00) begin errors++; $display("FAIL reset_out_keep: got %0h expected 0", out_keep); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last: got %0h expected 0", out_last); end
    checks++; if (curr_sn !== 32'd0) begin errors++; $display("FAIL reset_curr_sn: got %0h expected 0", curr_sn); end
    checks++; if (err_sn !== 1'b0) begin errors++; $display("FAIL reset_err_sn: got %0h expected 0", err_sn); end
    checks++; if (in_ready !== 8'h00) begin errors++; $display("FAIL reset_in_ready: got %0h expected 0", in_ready); end
    reset = 1'b0;
  endtask

  task automatic test_in_order();
    do_reset(); out_ready = 1'b1;
    @(negedge clk); set_batch(32'd0, 8'hA5, 1'b0, 8'hFF); #1;
    checks++; if (in_ready !== 8'hFF) begin errors++; $display("FAIL inorder_ready: got %0h expected ff", in_ready); end
    @(negedge clk); in_valid = '0; #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL inorder_latency: got %0h expected 0", out_valid); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL inorder_valid: got %0h expected 1", out_valid); end
    checks++; if (out_keep !== 8'hA5) begin errors++; $display("FAIL inorder_keep: got %0h expected a5", out_keep); end
    checks++; if (out_data !== exp_data(32'd0)) begin errors++; $display("FAIL inorder_data: got %0h expected %0h", out_data, exp_data(32'd0)); end
    checks++; if (curr_sn !== 32'd1) begin errors++; $display("FAIL inorder_curr_sn: got %0h expected 1", curr_sn); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL inorder_last: got %0h expected 0", out_last); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL inorder_drained: got %0h expected 0", out_valid); end
  endtask

  task automatic test_out_of_order();
    do_reset(); out_ready = 1'b1;
    @(negedge clk); set_batch(32'd1, 8'hFF, 1'b0, 8'hFF);
    @(negedge clk); #1;
    checks++; if (out_valid !== 1'b0 || curr_sn !== 32'd0) begin errors++; $display("FAIL ooo_hold: got valid=%0h sn=%0h expected valid=0 sn=0", out_valid, curr_sn); end
    set_batch(32'd0, 8'hFF, 1'b0, 8'hFF);
    @(negedge clk); in_valid = '0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || out_data !== exp_data(32'd0)) begin errors++; $display("FAIL ooo_beat0: got valid=%0h data=%0h expected valid=1 data=%0h", out_valid, out_data, exp_data(32'd0)); end
    checks++; if (curr_sn !== 32'd1) begin errors++; $display("FAIL ooo_sn1: got %0h expected 1", curr_sn); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || out_data !== exp_data(32'd1)) begin errors++; $display("FAIL ooo_beat1: got valid=%0h data=%0h expected valid=1 data=%0h", out_valid, out_data, exp_data(32'd1)); end
    checks++; if (curr_sn !== 32'd2) begin errors++; $display("FAIL ooo_sn2: got %0h expected 2", curr_sn); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ooo_done: got %0h expected 0", out_valid); end
  endtask

  task automatic test_window_stall();
    do_reset(); out_ready = 1'b1;
    @(negedge clk); set_batch(32'd0, 8'hFF, 1'b0, 8'hF7); set_lane(3, 32'd2, 32'd3, 1'b1, 1'b0, 1'b1); #1;
    checks++; if (in_ready !== 8'hF7) begin errors++; $display("FAIL stall_ahead: got %0h expected f7", in_ready); end
    @(negedge clk); in_valid = '0;
    set_lane(0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b1);
    set_lane(3, 32'd0, 32'd3, 1'b1, 1'b0, 1'b1); #1;
    checks++; if (in_ready[0] !== 1'b0 || in_ready[3] !== 1'b1) begin errors++; $display("FAIL stall_dup: got %0h expected lane0=0 lane3=1", in_ready); end
    @(negedge clk); in_valid = '0; set_lane(3, 32'd2, 32'd3, 1'b1, 1'b0, 1'b1); #1;
    checks++; if (in_ready[3] !== 1'b0) begin errors++; $display("FAIL stall_still: got %0h expected 0", in_ready[3]); end
    @(negedge clk); #1;
    checks++; if (curr_sn !== 32'd1 || in_ready[3] !== 1'b1) begin errors++; $display("FAIL stall_release: got sn=%0h rdy=%0h expected sn=1 rdy=1", curr_sn, in_ready[3]); end
    @(negedge clk); in_valid = '0;
  endtask

  task automatic test_backpressure();
    do_reset(); out_ready = 1'b0;
    @(negedge clk); set_batch(32'd0, 8'h3C, 1'b0, 8'hFF);
    @(negedge clk); set_batch(32'd1, 8'hC3, 1'b0, 8'hFF);
    @(negedge clk); in_valid = '0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++; if (out_valid !== 1'b1 || out_data !== exp_data(32'd0) || out_keep !== 8'h3C) begin errors++; $display("FAIL bp_hold%0d: got valid=%0h keep=%0h expected valid=1 keep=3c", c, out_valid, out_keep); end
      checks++; if (curr_sn !== 32'd1) begin errors++; $display("FAIL bp_sn%0d: got %0h expected 1", c, curr_sn); end
      checks++; if (in_ready !== 8'h00) begin errors++; $display("FAIL bp_ready%0d: got %0h expected 0", c, in_ready); end
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || out_data !== exp_data(32'd1) || out_keep !== 8'hC3) begin errors++; $display("FAIL bp_beat1: got valid=%0h keep=%0h expected valid=1 keep=c3", out_valid, out_keep); end
    checks++; if (curr_sn !== 32'd2) begin errors++; $display("FAIL bp_sn2: got %0h expected 2", curr_sn); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_empty: got %0h expected 0", out_valid); end
  endtask

  task automatic test_miss_and_last();
    do_reset(); out_ready = 1'b0;
    @(negedge clk); set_batch(32'd0, 8'h00, 1'b0, 8'hFF);
    @(negedge clk); in_valid = '0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || curr_sn !== 32'd1) begin errors++; $display("FAIL miss_silent: got valid=%0h sn=%0h expected valid=0 sn=1", out_valid, curr_sn); end
    set_batch(32'd1, 8'h00, 1'b1, 8'hFF);
    @(negedge clk); in_valid = '0;
    @(negedge clk); set_batch(32'd2, 8'h00, 1'b0, 8'h00); #1;
    checks++; if (out_valid !== 1'b1 || out_keep !== 8'h00 || out_last !== 1'b1) begin errors++; $display("FAIL last_beat: got valid=%0h keep=%0h last=%0h expected 1 0 1", out_valid, out_keep, out_last); end
    checks++; if (in_ready !== 8'h00 || curr_sn !== 32'd2) begin errors++; $display("FAIL drain_state: got rdy=%0h sn=%0h expected rdy=0 sn=2", in_ready, curr_sn); end
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (out_valid !== 1'b0 || in_ready !== 8'h00 || curr_sn !== 32'd2) begin errors++; $display("FAIL done_state: got valid=%0h rdy=%0h sn=%0h expected 0 0 2", out_valid, in_ready, curr_sn); end
  endtask

  task automatic test_errors_and_reset();
    do_reset(); out_ready = 1'b1;
    @(negedge clk); set_batch(32'd0, 8'hFF, 1'b0, 8'hFF); set_lane(5, 32'd0, 32'd2, 1'b1, 1'b0, 1'b1); #1;
    checks++; if (err_sn !== 1'b0) begin errors++; $display("FAIL err_before: got %0h expected 0", err_sn); end
    @(negedge clk); in_valid = '0;
    checks++; if (err_sn !== 1'b1) begin errors++; $display("FAIL err_lane_idx: got %0h expected 1", err_sn); end
    @(negedge clk); set_lane(0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b1); #1;
    checks++; if (curr_sn !== 32'd1 || in_ready[0] !== 1'b1) begin errors++; $display("FAIL behind_ready: got sn=%0h rdy=%0h expected sn=1 rdy=1", curr_sn, in_ready[0]); end
    @(negedge clk); set_batch(32'd1, 8'hFF, 1'b0, 8'h0F); #1;
    checks++; if (err_sn !== 1'b1 || in_ready[3:0] !== 4'hF) begin errors++; $display("FAIL err_sticky: got err=%0h rdy=%0h expected err=1 rdy=f", err_sn, in_ready[3:0]); end
    @(negedge clk); in_valid = '0; reset = 1'b1;
    @(negedge clk); #1;
    checks++; if (out_valid !== 1'b0 || out_data !== 512'd0 || out_keep !== 8'h00 || out_last !== 1'b0) begin errors++; $display("FAIL midreset_out: got valid=%0h keep=%0h last=%0h expected all 0", out_valid, out_keep, out_last); end
    checks++; if (curr_sn !== 32'd0 || err_sn !== 1'b0 || in_ready !== 8'h00) begin errors++; $display("FAIL midreset_state: got sn=%0h err=%0h rdy=%0h expected all 0", curr_sn, err_sn, in_ready); end
    reset = 1'b0;
    @(negedge clk); set_batch(32'd1, 8'hFF, 1'b0, 8'h00); #1;
    checks++; if (in_ready !== 8'hFF) begin errors++; $display("FAIL midreset_slots: got %0h expected ff", in_ready); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; out_ready = 1'b0;
    in_valid = '0; in_data = '0; in_hit = '0; in_serialnum = '0; in_last = '0;
    test_reset();
    test_in_order();
    test_out_of_order();
    test_window_stall();
    test_backpressure();
    test_miss_and_last();
    test_errors_and_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/probe_result_collector.md
# probe_result_collector

Downstream stage of the 8-lane probe datapath. Collects per-lane probe results tagged with the serial numbers issued by the AXI-to-stream converter, reassembles them into in-order 512-bit result beats, and publishes `curr_sn` back to the converter. Because the converter gates issue on `count < curr_sn + MAX_IN_TRANSIT`, this block's `curr_sn` is the credit return closing the probe-side flow-control loop.

## Interface
- `MAX_IN_TRANSIT`, default 2: number of reorder slots and serial numbers in flight. Power of two, ≥1, and equal to the converter's value.
- `clk` in 1: single clock; all logic on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `in_valid` in 8: per-lane result valid.
- `in_ready` out 8: per-lane result ready.
- `in_data` in 8×64: per-lane result word.
- `in_hit` in 8: 1 = probe match; `in_data` is meaningful only when set.
- `in_serialnum` in 8×64: [31:0] = batch serial number; [63:32] = lane index.
- `in_last` in 8: lane carries the final batch.
- `out_data` out 512: lane i occupies bits [64i+63:64i].
- `out_keep` out 8: per-lane hit mask of the beat.
- `out_valid` out 1: beat valid.
- `out_ready` in 1: beat ready.
- `out_last` out 1: final beat.
- `curr_sn` out 32: oldest serial number not yet retired.
- `err_sn` out 1: sticky; serial number behind window or lane-index mismatch.

## Operation
- Storage: `MAX_IN_TRANSIT` slots, each holding 8×64 data, 8 hit bits, 8 fill bits and 1 last bit. Slot index = `sn[31:0] mod MAX_IN_TRANSIT`.
- Window: `sn` is in window iff `sn − curr_sn` (32-bit unsigned, wraps) < `MAX_IN_TRANSIT`.
- `in_ready[i]` = state RUN ∧ in window ∧ fill[slot][i] == 0. It is computed from registered state only and depends on `in_serialnum[i]`, not on `in_valid`.
- Stall cases:
  - Serial number ahead of window: `in_ready[i]`=0.
  - Serial number behind window (difference ≥ 2^31): `in_ready[i]`=1, word dropped, `err_sn` set.
  - `in_serialnum[i][63:32] ≠ i`: word accepted into lane i, `err_sn` set.
- Accept (`in_valid[i]` ∧ `in_ready[i]`): write data, hit and fill bit into the slot; OR `in_last[i]` into the slot's last bit. All 8 lanes may write in the same cycle, to different slots.
- Retire: the head slot (`curr_sn mod N`) is retired when all 8 fill bits are set and the output register is empty or draining (`out_valid ∧ out_ready`). On the same edge:
  - Load `out_data` and `out_keep`.
  - `out_valid` = 1 if keep ≠ 0 or last = 1. An all-miss, non-last batch retires silently with no beat.
  - Load `out_last` ← slot last bit.
  - Clear the slot.
  - `curr_sn` ← `curr_sn` + 1, wrapping at 2^32.
- States:
  - RUN → DRAIN on retiring a slot whose last bit is set.
  - DRAIN (all `in_ready`=0) → DONE when the last beat handshakes.
  - DONE holds until reset. `curr_sn` is frozen in DRAIN and DONE.
- Reset values: `in_ready`=0, `out_data`=0, `out_keep`=0, `out_valid`=0, `out_last`=0, `curr_sn`=0, `err_sn`=0, all fill and last bits 0, state RUN.
- Reset mid-operation discards all slots and any pending beat. The converter must be reset in the same cycle.

## Timing
- A word accepted at edge k that completes the head slot gives `out_valid`=1 and `curr_sn`+1 after edge k+1. Latency is 1 cycle.
- Throughput: one batch per cycle when slots are full and `out_ready`=1.
- `out_data`, `out_keep` and `out_last` are stable while `out_valid` ∧ ¬`out_ready`. A retire is blocked while a beat is pending and not draining.
- A slot cleared at edge k is writable from cycle k+1, because the window advances with registered `curr_sn`. There are no same-cycle write/clear hazards.
- `curr_sn` wrap from 0xFFFFFFFF to 0 keeps window arithmetic correct.

## Test plan
- **In-order batch:** after reset, sn=0, all 8 lanes valid together, `in_hit`=8'hA5, `out_ready`=1 → one cycle later `out_valid`=1, `out_keep`=8'hA5, lane data in place, `curr_sn`=1.
- **Out-of-order lanes, N=2:** batch sn=1 completes before sn=0 → no beat until sn=0 completes; beats then emit sn0 then sn1 on consecutive cycles; `curr_sn` 0→2.
- **Window stall:** lane 3 presents sn=2 while `curr_sn`=0 → `in_ready[3]`=0 until `curr_sn`=1; duplicate lane write to a filled slot → `in_ready`=0.
- **Backpressure:** `out_ready`=0 for 5 cycles with both slots full → beat held stable, `curr_sn` frozen, all `in_ready`=0; release → two beats back-to-back.
- **All-miss and last:** batch sn=0 all misses, non-last → no beat, `curr_sn`=1. Batch sn=1 all misses with `in_last` → beat with keep=0, `out_last`=1; after handshake, state DONE and `in_ready`=0.
- **Errors and reset:** lane 5 sends lane index 2 → `err_sn`=1 and stays 1; `reset` asserted mid-batch → next cycle all outputs 0, slots empty, `curr_sn`=0.
